// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_add_fa.sv
// One-bit full-adder cell, purely combinational; the serial controller time-shares it.
module fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one shared full-adder cell, LSB first, one bit per clock.
// Define SERIAL_ADD_OVF_EN to build the registered signed-overflow flag.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit added per edge, carry kept in r_carry
// DONE  | result valid, done high for this one cycle
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    seq_state_t       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_last;

    fa u_fa (
        .i_a  (r_a_sh[0]),
        .i_b  (r_b_sh[0]),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    // Only the upper WIDTH-1 partial sum bits are stored; the current cell
    // output completes the word on the final edge.
    assign w_sum_next = {w_s, r_sum_sh};
    assign w_last     = (r_cnt == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_sum_sh <= w_sum_next[WIDTH-1:1];
                    r_carry  <= w_co;
                    if (w_last) begin
                        r_sum   <= w_sum_next;
                        r_cout  <= w_co;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // r_carry on the last RUN edge is the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && w_last) begin
            r_ovf <= r_carry ^ w_co;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed self-checking bench for serial_add_seq at WIDTH=8.
module tb_serial_add_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    serial_add_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ovf(input logic v);
`ifdef SERIAL_ADD_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    // Waits at negedges until done; returns edges counted from the accepting edge.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_op, input logic tc,
                         input logic [7:0] es, input logic ec, input logic eo, input string tag);
        int edges;
        int bcnt;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_op; cin = tc;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_op; cin = ~tc;
        wait_done(edges, bcnt);
        chk({tag, "_latency"}, edges, 9);
        chk({tag, "_busy"}, bcnt, 8);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, exp_ovf(eo));
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_sum_hold"}, sum, es);
    endtask

    initial begin
        int edges;
        int bcnt;
        int n_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "5a_3c");
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ff_01");
        do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "7f_01");
        do_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "cin_only");

        // Start during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'hAA;
        @(negedge clk);
        start = 1'b0;
        edges = 0; n_done = 0;
        while (done !== 1'b1 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        chk("ign_done_seen", done, 1);
        chk("ign_sum", sum, 8'h33);
        chk("ign_cout", cout, 0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        chk("ign_no_second_run", n_done, 0);

        // Back-to-back: start held through DONE.
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(negedge clk);
        a = 8'h01; b = 8'h01;
        wait_done(edges, bcnt);
        chk("b2b_first_latency", edges, 9);
        chk("b2b_first_sum", sum, 8'h46);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_idle", busy, 1);
        wait_done(edges, bcnt);
        chk("b2b_second_latency", edges, 9);
        chk("b2b_second_sum", sum, 8'h02);
        chk("b2b_second_cout", cout, 0);

        // Asynchronous reset in the middle of a run.
        do_op(8'hC3, 8'h81, 1'b1, 8'h45, 1'b1, 1'b1, "pre_rst");
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_sum", sum, 0);
        chk("arst_cout", cout, 0);
        chk("arst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        chk("arst_no_done", n_done, 0);
        do_op(8'h0F, 8'hF1, 1'b1, 8'h01, 1'b1, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial addition controller. It time-shares a single one-bit full-adder cell across the WIDTH bit positions of two operands, LSB first, with one bit per clock. It captures operands on a start handshake, sequences the cell through the bits while carrying between them, and presents a registered sum and carry-out with a one-cycle done pulse. It sits beside the combinational adder cells as the area-minimal alternative to a WIDTH-bit ripple adder.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in IDLE or DONE.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- cin  in  1  carry-in; sampled on the accepting edge only.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  result; held stable from done until the next accepted start.
- cout  out  1  final carry-out; held like sum.
- ovf  out  1  signed overflow (see Configuration).

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- **Reset** (asynchronous, any state including mid-RUN):
  - State goes to IDLE; any operation in progress is discarded with no done.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal carry, bit counter and operand shift registers are cleared.
- **Accept.** start=1 in IDLE or DONE at a rising edge:
  - Load a_sh←a, b_sh←b, carry←cin, cnt←0.
  - Go to RUN.
- **Ignored start.** start in RUN has no effect; the operands are not resampled.
- **RUN, each edge.**
  - The cell evaluates a_sh[0], b_sh[0] and carry.
  - sum_sh shifts right with the cell's sum bit entering at the MSB.
  - a_sh and b_sh shift right; carry←cell co; cnt←cnt+1.
- **End of RUN.** On the edge where cnt==WIDTH-1:
  - Load sum←final sum_sh and cout←cell co.
  - Go to DONE.
- **DONE** lasts one cycle with done=1.
  - Next state is RUN if start=1, otherwise IDLE.
  - sum and cout are unchanged by that transition.
- **Counter.** cnt width is $clog2(WIDTH); it never wraps inside a run.
- **Arithmetic.** The result equals (a + b + cin) mod 2^WIDTH, with cout as bit WIDTH.

## Timing
- Accepting edge = E0. busy is high from after E0 through after E(WIDTH-1).
- done is high in the single cycle after edge E(WIDTH).
- Latency from the accepting edge to done: WIDTH+1 edges.
- Back-to-back: start held high gives one result every WIDTH+1 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- The macro SERIAL_ADD_OVF_EN selects the overflow logic.
- **Defined:**
  - The block keeps the carry into the MSB (the carry register at cnt==WIDTH-1).
  - ovf = that carry XOR final cout, registered with sum.
  - ovf is reset to 0.
- **Undefined:** ovf is tied to 0 and no extra flops are inferred.

## Structure
- **Package serial_add_pkg:**
  - State enum seq_state_t {IDLE, RUN, DONE}.
  - Localparam for the maximum WIDTH (32).
- **Sub-module:** one instance of the existing fa one-bit full-adder cell as the shared datapath.
  - The controller owns all registers; fa stays purely combinational.

## Test plan
Test plan uses WIDTH=8.
- a=0x5A, b=0x3C, cin=0, start one cycle:
  - busy high for 8 cycles, done pulses 9 edges after accept.
  - sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; with OVF_EN, ovf=0.
- a=0x7F, b=0x01, cin=0 with OVF_EN → sum=0x80, cout=0, ovf=1. a=0x00, b=0x00, cin=1 → sum=0x01.
- Start 0x11+0x22; pulse start with a=0xAA at RUN cycle 3:
  - The second request is ignored and no second run follows the first.
  - sum=0x33, exactly one done.
- Start 0x12+0x34; hold start with the next operands a=0x01, b=0x01 present when done is high:
  - The first done shows sum=0x46.
  - The second run starts from DONE with no IDLE cycle; the second done shows 0x02.
- Assert rst asynchronously mid-RUN, off a clock edge:
  - busy, done, sum and cout go to 0 immediately and no done follows.
  - The next start then produces a correct result.
